// File: rtl/nios2_oci_debug_mem.sv
// Nios II OCI debug memory: JTAG monitor access to a small single-port RAM,
// shared with a CPU Avalon-MM slave that stalls while the debug side owns the port.
module nios2_oci_debug_mem #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_e;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  logic [ADDR_W-1:0] monAReg_q;
  logic [ADDR_W-1:0] monAIncr_d;
  logic [31:0]       monDReg_q;
  logic [31:0]       wdata_q;
  logic [31:0]       ramQ_q;
  logic              monReady_q;
  logic              monError_q;
  logic              pending_q;
  logic              opWrite_q;
  logic              issueOk_q;
  logic              rdValid_q;

  logic [31:0]       mem [DEPTH];

  logic              inIssue;
  logic              anyStrobe;
  logic              cpuRead;
  logic              cpuWrite;
  logic              dbgInRange;
  logic              cpuInRange;
  logic              dbgRead;
  logic              dbgWrite;
  logic [ADDR_W-1:0] ramAddr;
  logic              unusedJdo;

  assign unusedJdo  = ^{jdo[37:36], jdo[33:32]};
  assign inIssue    = (state_q == ISSUE);
  assign anyStrobe  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign monAIncr_d = monAReg_q + 1'b1;

  // The debug side owns the single RAM port in ISSUE; the CPU gets it otherwise.
  assign cpuRead    = avs_read & ~inIssue;
  assign cpuWrite   = avs_write & ~avs_read & ~inIssue;
  assign dbgInRange = ({1'b0, monAReg_q} < DEPTH_W);
  assign cpuInRange = ({1'b0, avs_address} < DEPTH_W);
  assign dbgRead    = inIssue & ~opWrite_q & dbgInRange;
  assign dbgWrite   = inIssue & opWrite_q & dbgInRange;
  assign ramAddr    = inIssue ? monAReg_q : avs_address;

  assign avs_waitrequest   = (avs_read | avs_write) & inIssue;
  assign avs_readdata      = ramQ_q;
  assign avs_readdatavalid = rdValid_q;
  assign MonDReg           = monDReg_q;
  assign monitor_ready     = monReady_q;
  assign monitor_error     = monError_q;

  always_ff @(posedge clk) begin
    if (dbgWrite) begin
      mem[ramAddr] <= wdata_q;
    end else if (cpuWrite && cpuInRange) begin
      for (int b = 0; b < 4; b++) begin
        if (avs_byteenable[b]) mem[ramAddr][8*b +: 8] <= avs_writedata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ramQ_q    <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdValid_q <= cpuRead;
      if (dbgRead) begin
        ramQ_q <= mem[ramAddr];
      end else if (cpuRead) begin
        ramQ_q <= cpuInRange ? mem[ramAddr] : '0;
      end
    end
  end

  // Later assignments to monError_q win, so a dropped or stray strobe always flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      monAReg_q  <= '0;
      monDReg_q  <= '0;
      wdata_q    <= '0;
      monReady_q <= 1'b0;
      monError_q <= 1'b0;
      pending_q  <= 1'b0;
      opWrite_q  <= 1'b0;
      issueOk_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pending_q <= 1'b0;
          if (pending_q) monReady_q <= 1'b1;
          if (take_action_ocimem_b) begin
            wdata_q    <= jdo[31:0];
            opWrite_q  <= 1'b1;
            monReady_q <= 1'b0;
            state_q    <= ISSUE;
            if (take_action_ocimem_a || take_no_action_ocimem_a) monError_q <= 1'b1;
          end else if (take_action_ocimem_a) begin
            monAReg_q  <= jdo[ADDR_W+1:2];
            opWrite_q  <= 1'b0;
            monReady_q <= 1'b0;
            if (jdo[35]) monError_q <= 1'b0;
            if (take_no_action_ocimem_a) monError_q <= 1'b1;
            if (jdo[34]) state_q <= ISSUE;
            else pending_q <= 1'b1;
          end else if (take_no_action_ocimem_a) begin
            monAReg_q  <= monAIncr_d;
            opWrite_q  <= 1'b0;
            monReady_q <= 1'b0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          issueOk_q <= dbgInRange;
          if (!dbgInRange || anyStrobe) monError_q <= 1'b1;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          if (!opWrite_q && issueOk_q) monDReg_q <= ramQ_q;
          if (opWrite_q) monAReg_q <= monAIncr_d;
          if (anyStrobe) monError_q <= 1'b1;
          monReady_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_oci_debug_mem.sv
// Bench for nios2_oci_debug_mem: two instances (DEPTH 256 and 200) share stimulus
// and are checked against a word-array reference model of the debug/CPU behaviour.
module tb_nios2_oci_debug_mem;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [37:0] jdo = '0;
  logic        ta = 1'b0, tn = 1'b0, tb = 1'b0;
  logic [7:0]  avsAddr = '0;
  logic        avsRead = 1'b0, avsWrite = 1'b0;
  logic [31:0] avsWdata = '0;
  logic [3:0]  avsBe = '0;

  logic [31:0] monD [2];
  logic [31:0] rdata [2];
  logic        monRdy [2], monErr [2], rdv [2], wr [2];

  int checks = 0;
  int errors = 0;

  // Reference model: plain word arrays, one per instance depth.
  int          depthOf [2] = '{256, 200};
  logic [31:0] mMem [2][256];
  logic [31:0] mD [2];
  logic        mErr [2];
  int          mA [2];

  always #5 clk = ~clk;

  nios2_oci_debug_mem #(.ADDR_W(8), .DEPTH(256)) dut256 (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(ta), .take_no_action_ocimem_a(tn), .take_action_ocimem_b(tb),
    .MonDReg(monD[0]), .monitor_ready(monRdy[0]), .monitor_error(monErr[0]),
    .avs_address(avsAddr), .avs_read(avsRead), .avs_write(avsWrite),
    .avs_writedata(avsWdata), .avs_byteenable(avsBe),
    .avs_readdata(rdata[0]), .avs_readdatavalid(rdv[0]), .avs_waitrequest(wr[0]));

  nios2_oci_debug_mem #(.ADDR_W(8), .DEPTH(200)) dut200 (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(ta), .take_no_action_ocimem_a(tn), .take_action_ocimem_b(tb),
    .MonDReg(monD[1]), .monitor_ready(monRdy[1]), .monitor_error(monErr[1]),
    .avs_address(avsAddr), .avs_read(avsRead), .avs_write(avsWrite),
    .avs_writedata(avsWdata), .avs_byteenable(avsBe),
    .avs_readdata(rdata[1]), .avs_readdatavalid(rdv[1]), .avs_waitrequest(wr[1]));

  function automatic logic [37:0] mkA(input int addr, input bit rd, input bit clr);
    logic [37:0] d;
    d = '0;
    d[9:2] = addr[7:0];
    d[34] = rd;
    d[35] = clr;
    return d;
  endfunction

  function automatic logic [31:0] expCpuRead(input int k, input int addr);
    return (addr < depthOf[k]) ? mMem[k][addr] : 32'h0;
  endfunction

  // kind: 0 = ocimem_a, 1 = no_action_a, 2 = ocimem_b, 3 = ocimem_b with ocimem_a dropped
  task automatic modelDbg(input int kind, input logic [37:0] d);
    bit rd;
    for (int k = 0; k < 2; k++) begin
      if (kind >= 2) begin
        if (mA[k] < depthOf[k]) mMem[k][mA[k]] = d[31:0];
        else mErr[k] = 1'b1;
        mA[k] = (mA[k] + 1) % 256;
        if (kind == 3) mErr[k] = 1'b1;
      end else begin
        if (kind == 0) begin
          mA[k] = int'(d[9:2]);
          if (d[35]) mErr[k] = 1'b0;
          rd = d[34];
        end else begin
          mA[k] = (mA[k] + 1) % 256;
          rd = 1'b1;
        end
        if (rd) begin
          if (mA[k] < depthOf[k]) mD[k] = mMem[k][mA[k]];
          else mErr[k] = 1'b1;
        end
      end
    end
  endtask

  // Returns at the negedge where monitor_ready must be 1; early holds ready one cycle before.
  task automatic dbgOp(input int kind, input logic [37:0] d, output logic [1:0] early);
    bit issue;
    issue = (kind != 0) || d[34];
    @(negedge clk);
    jdo = d;
    ta = (kind == 0) || (kind == 3);
    tn = (kind == 1);
    tb = (kind >= 2);
    @(negedge clk);
    ta = 1'b0; tn = 1'b0; tb = 1'b0;
    if (issue) @(negedge clk);
    early = {monRdy[1], monRdy[0]};
    @(negedge clk);
    modelDbg(kind, d);
  endtask

  task automatic cpuWrite(input int addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    avsAddr = addr[7:0]; avsWdata = data; avsBe = be; avsWrite = 1'b1;
    @(negedge clk);
    avsWrite = 1'b0;
    for (int k = 0; k < 2; k++)
      if (addr < depthOf[k])
        for (int b = 0; b < 4; b++)
          if (be[b]) mMem[k][addr][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic cpuRead(input int addr, output logic [31:0] d0, output logic [31:0] d1,
                         output logic [1:0] v1, output logic [1:0] v2);
    @(negedge clk);
    avsAddr = addr[7:0]; avsRead = 1'b1;
    @(negedge clk);
    avsRead = 1'b0;
    d0 = rdata[0]; d1 = rdata[1];
    v1 = {rdv[1], rdv[0]};
    @(negedge clk);
    v2 = {rdv[1], rdv[0]};
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++; if (monD[k] !== 32'h0) begin errors++; $display("[TB] FAIL rst_monD k=%0d got %h exp 0", k, monD[k]); end
      checks++; if (monRdy[k] !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready k=%0d got %b exp 0", k, monRdy[k]); end
      checks++; if (monErr[k] !== 1'b0) begin errors++; $display("[TB] FAIL rst_error k=%0d got %b exp 0", k, monErr[k]); end
      checks++; if (rdv[k] !== 1'b0 || rdata[k] !== 32'h0) begin errors++; $display("[TB] FAIL rst_avs k=%0d got v=%b d=%h exp 0", k, rdv[k], rdata[k]); end
      checks++; if (wr[k] !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait k=%0d got %b exp 0", k, wr[k]); end
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin mD[k] = '0; mErr[k] = 1'b0; mA[k] = 0; end
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) cpuWrite(i, $urandom, 4'hF);
  endtask

  task automatic test_write_read();
    logic [1:0] early;
    dbgOp(0, mkA(5, 1'b0, 1'b0), early);
    checks++; if (early !== 2'b00 || monRdy[0] !== 1'b1 || monRdy[1] !== 1'b1) begin
      errors++; $display("[TB] FAIL wr_setaddr_ready got early=%b now=%b%b exp 00/11", early, monRdy[1], monRdy[0]); end
    dbgOp(2, {6'b0, 32'hDEADBEEF}, early);
    checks++; if (early !== 2'b00 || monRdy[0] !== 1'b1 || monRdy[1] !== 1'b1) begin
      errors++; $display("[TB] FAIL wr_write_ready got early=%b now=%b%b exp 00/11", early, monRdy[1], monRdy[0]); end
    dbgOp(0, mkA(5, 1'b1, 1'b0), early);
    for (int k = 0; k < 2; k++) begin
      checks++; if (monD[k] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr_readback k=%0d got %h exp deadbeef", k, monD[k]); end
      checks++; if (early[k] !== 1'b0 || monRdy[k] !== 1'b1) begin errors++; $display("[TB] FAIL wr_read_ready k=%0d got %b%b exp 01", k, early[k], monRdy[k]); end
    end
    // Address auto-incremented to 6 after the write: a no-action read must fetch word 6.
    dbgOp(1, '0, early);
    for (int k = 0; k < 2; k++) begin
      checks++; if (monD[k] !== mD[k]) begin errors++; $display("[TB] FAIL wr_next_addr k=%0d got %h exp %h", k, monD[k], mD[k]); end
    end
  endtask

  task automatic test_no_action();
    logic [1:0] early;
    dbgOp(0, mkA(5, 1'b0, 1'b0), early);
    dbgOp(2, {6'b0, 32'h11111111}, early);
    dbgOp(2, {6'b0, 32'h22222222}, early);
    dbgOp(0, mkA(5, 1'b1, 1'b0), early);
    dbgOp(1, '0, early);
    for (int k = 0; k < 2; k++) begin
      checks++; if (monD[k] !== 32'h22222222) begin errors++; $display("[TB] FAIL na_read k=%0d got %h exp 22222222", k, monD[k]); end
    end
    dbgOp(0, mkA(255, 1'b1, 1'b0), early);
    dbgOp(1, '0, early);
    for (int k = 0; k < 2; k++) begin
      checks++; if (monD[k] !== mD[k]) begin errors++; $display("[TB] FAIL na_wrap k=%0d got %h exp %h", k, monD[k], mD[k]); end
      checks++; if (monErr[k] !== mErr[k]) begin errors++; $display("[TB] FAIL na_wrap_err k=%0d got %b exp %b", k, monErr[k], mErr[k]); end
    end
    dbgOp(0, mkA(0, 1'b0, 1'b1), early);
  endtask

  task automatic test_out_of_range();
    logic [1:0] early;
    dbgOp(0, mkA(250, 1'b1, 1'b0), early);
    for (int k = 0; k < 2; k++) begin
      checks++; if (monErr[k] !== mErr[k]) begin errors++; $display("[TB] FAIL oor_err k=%0d got %b exp %b", k, monErr[k], mErr[k]); end
      checks++; if (monD[k] !== mD[k]) begin errors++; $display("[TB] FAIL oor_monD k=%0d got %h exp %h", k, monD[k], mD[k]); end
      checks++; if (monRdy[k] !== 1'b1) begin errors++; $display("[TB] FAIL oor_ready k=%0d got %b exp 1", k, monRdy[k]); end
    end
    checks++; if (monErr[1] !== 1'b1) begin errors++; $display("[TB] FAIL oor_err200 got %b exp 1", monErr[1]); end
    dbgOp(0, mkA(250, 1'b0, 1'b1), early);
    for (int k = 0; k < 2; k++) begin
      checks++; if (monErr[k] !== 1'b0) begin errors++; $display("[TB] FAIL oor_clear k=%0d got %b exp 0", k, monErr[k]); end
    end
  endtask

  task automatic test_cpu_bytes();
    logic [31:0] d0, d1;
    logic [1:0]  v1, v2;
    cpuWrite(3, 32'h0, 4'hF);
    cpuWrite(3, 32'hAABBCCDD, 4'b0101);
    cpuRead(3, d0, d1, v1, v2);
    checks++; if (d0 !== 32'h00BB00DD || d1 !== 32'h00BB00DD) begin
      errors++; $display("[TB] FAIL cpu_bytes got %h/%h exp 00bb00dd", d0, d1); end
    checks++; if (v1 !== 2'b11 || v2 !== 2'b00) begin
      errors++; $display("[TB] FAIL cpu_valid got %b then %b exp 11 then 00", v1, v2); end
    cpuRead(230, d0, d1, v1, v2);
    checks++; if (d0 !== mMem[0][230] || d1 !== 32'h0 || v1 !== 2'b11) begin
      errors++; $display("[TB] FAIL cpu_oor got %h/%h v=%b exp %h/0 v=11", d0, d1, v1, mMem[0][230]); end
  endtask

  task automatic test_contention();
    logic [1:0] early;
    @(negedge clk);
    jdo = mkA(10, 1'b1, 1'b0); ta = 1'b1;
    @(negedge clk);
    ta = 1'b0; avsRead = 1'b1; avsAddr = 8'd20;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (wr[k] !== 1'b1) begin errors++; $display("[TB] FAIL cont_wait_issue k=%0d got %b exp 1", k, wr[k]); end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (wr[k] !== 1'b0 || rdv[k] !== 1'b0) begin
        errors++; $display("[TB] FAIL cont_capture k=%0d got wait=%b valid=%b exp 0/0", k, wr[k], rdv[k]); end
    end
    @(negedge clk);
    avsRead = 1'b0;
    modelDbg(0, mkA(10, 1'b1, 1'b0));
    for (int k = 0; k < 2; k++) begin
      checks++; if (rdv[k] !== 1'b1 || rdata[k] !== expCpuRead(k, 20)) begin
        errors++; $display("[TB] FAIL cont_cpu k=%0d got v=%b d=%h exp 1/%h", k, rdv[k], rdata[k], expCpuRead(k, 20)); end
      checks++; if (monD[k] !== mD[k] || monRdy[k] !== 1'b1) begin
        errors++; $display("[TB] FAIL cont_dbg k=%0d got %h r=%b exp %h r=1", k, monD[k], monRdy[k], mD[k]); end
    end
    @(negedge clk);
    checks++; if (rdv[0] !== 1'b0 || rdv[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL cont_pulse got %b%b exp 00", rdv[1], rdv[0]); end
    // Stray strobe during CAPTURE.
    jdo = mkA(30, 1'b1, 1'b0); ta = 1'b1;
    @(negedge clk); ta = 1'b0;
    @(negedge clk); tn = 1'b1;
    @(negedge clk); tn = 1'b0;
    modelDbg(0, mkA(30, 1'b1, 1'b0));
    for (int k = 0; k < 2; k++) begin
      mErr[k] = 1'b1;
      checks++; if (monErr[k] !== 1'b1 || monD[k] !== mD[k] || monRdy[k] !== 1'b1) begin
        errors++; $display("[TB] FAIL cont_stray k=%0d got e=%b d=%h r=%b exp 1/%h/1", k, monErr[k], monD[k], monRdy[k], mD[k]); end
    end
    dbgOp(1, '0, early);
    for (int k = 0; k < 2; k++) begin
      checks++; if (monD[k] !== mD[k]) begin errors++; $display("[TB] FAIL cont_addr_kept k=%0d got %h exp %h", k, monD[k], mD[k]); end
    end
    dbgOp(0, mkA(0, 1'b0, 1'b1), early);
    dbgOp(3, {6'b0, 32'h5A5A1234}, early);
    for (int k = 0; k < 2; k++) begin
      checks++; if (monErr[k] !== 1'b1) begin errors++; $display("[TB] FAIL both_strobe_err k=%0d got %b exp 1", k, monErr[k]); end
    end
    dbgOp(0, mkA(0, 1'b1, 1'b0), early);
    for (int k = 0; k < 2; k++) begin
      checks++; if (monD[k] !== 32'h5A5A1234) begin errors++; $display("[TB] FAIL both_strobe_wr k=%0d got %h exp 5a5a1234", k, monD[k]); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  early;
    logic [31:0] d0, d1;
    logic [1:0]  v1, v2;
    int          op, addr;
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 4);
      addr = $urandom_range(0, 255);
      if (op <= 2) begin
        if (op == 0) dbgOp(0, mkA(addr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))), early);
        else if (op == 1) dbgOp(1, '0, early);
        else dbgOp(2, {6'b0, 32'($urandom)}, early);
        for (int k = 0; k < 2; k++) begin
          checks++; if (monD[k] !== mD[k] || monErr[k] !== mErr[k] || monRdy[k] !== 1'b1 || early[k] !== 1'b0) begin
            errors++; $display("[TB] FAIL rand_dbg it=%0d k=%0d got d=%h e=%b r=%b%b exp d=%h e=%b r=01",
                               it, k, monD[k], monErr[k], early[k], monRdy[k], mD[k], mErr[k]); end
        end
      end else if (op == 3) begin
        cpuWrite(addr, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        cpuRead(addr, d0, d1, v1, v2);
        checks++; if (d0 !== expCpuRead(0, addr) || d1 !== expCpuRead(1, addr) || v1 !== 2'b11 || v2 !== 2'b00) begin
          errors++; $display("[TB] FAIL rand_cpu it=%0d a=%0d got %h/%h v=%b%b exp %h/%h",
                             it, addr, d0, d1, v1, v2, expCpuRead(0, addr), expCpuRead(1, addr)); end
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [1:0] early;
    dbgOp(0, mkA(250, 1'b1, 1'b0), early);
    @(negedge clk);
    jdo = mkA(5, 1'b1, 1'b0); ta = 1'b1; avsRead = 1'b1; avsAddr = 8'd5;
    @(negedge clk);
    ta = 1'b0; avsRead = 1'b0;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (monD[k] !== 32'h0 || monRdy[k] !== 1'b0 || monErr[k] !== 1'b0 || rdv[k] !== 1'b0) begin
        errors++; $display("[TB] FAIL midrst k=%0d got d=%h r=%b e=%b v=%b exp all 0", k, monD[k], monRdy[k], monErr[k], rdv[k]); end
    end
    for (int k = 0; k < 2; k++) begin mD[k] = '0; mErr[k] = 1'b0; mA[k] = 0; end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dbgOp(0, mkA(7, 1'b1, 1'b0), early);
    for (int k = 0; k < 2; k++) begin
      checks++; if (monD[k] !== mD[k] || monErr[k] !== 1'b0 || monRdy[k] !== 1'b1 || early[k] !== 1'b0) begin
        errors++; $display("[TB] FAIL postrst k=%0d got d=%h e=%b r=%b exp %h/0/1", k, monD[k], monErr[k], monRdy[k], mD[k]); end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_write_read();
    test_no_action();
    test_out_of_range();
    test_cpu_bytes();
    test_contention();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
